// File: rtl/rand_arbiter.sv
// rand_arbiter: round-robin arbiter that hands each granted requester a random nibble below its bound
module rand_arbiter #(
    parameter int NREQ   = 4,
    parameter int MAXREJ = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       rnd,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] bound,
    output logic [NREQ-1:0]   gnt,
    output logic              valid,
    output logic [3:0]        data,
    output logic              busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DRAW = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [1:0]      last_q, last_d;
    logic [3:0]      bnd_q, bnd_d;
    logic [3:0]      rej_q, rej_d;
    logic [3:0]      data_q, data_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            valid_q, valid_d;
    logic [1:0]      pick, j;
    logic            found, acc, force_acc;
    logic            unused_rnd;

    assign unused_rnd = ^rnd[15:4];

    always_comb begin
        pick  = last_q;
        found = 1'b0;
        j     = last_q;
        for (int i = 1; i <= 4; i++) begin
            j = last_q + 2'(i);
            if (!found && req[j]) begin
                pick  = j;
                found = 1'b1;
            end
        end
    end

    // a latched bound of 0 means 16, so every nibble is acceptable
    assign acc       = (bnd_q == 4'd0) || (rnd[3:0] < bnd_q);
    assign force_acc = rej_q == 4'(MAXREJ);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        bnd_d   = bnd_q;
        rej_d   = rej_q;
        data_d  = data_q;
        gnt_d   = '0;
        valid_d = 1'b0;
        case (state_q)
            IDLE: if (found) begin
                idx_d   = pick;
                bnd_d   = bound[{pick, 2'b00} +: 4];
                rej_d   = 4'd0;
                state_d = DRAW;
            end
            DRAW: if (acc || force_acc) begin
                data_d       = acc ? rnd[3:0] : bnd_q - 4'd1;
                valid_d      = 1'b1;
                gnt_d[idx_q] = 1'b1;
                last_d       = idx_q;
                state_d      = DONE;
            end else begin
                rej_d = rej_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            last_q  <= 2'd3;
            bnd_q   <= 4'd0;
            rej_q   <= 4'd0;
            data_q  <= 4'd0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            bnd_q   <= bnd_d;
            rej_q   <= rej_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
        end
    end

    assign gnt   = gnt_q;
    assign valid = valid_q;
    assign data  = data_q;
    assign busy  = state_q != IDLE;
endmodule
